// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types for the divider sequencer
package div_ctrl_pkg;
    typedef enum logic {DIVOP = 1'b0, REMOP = 1'b1} divider_op_t;
endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - request, response and divider-side signals of div_ctrl
interface div_ctrl_if #(
    parameter int WORD_BITS = 64
) ();
    import div_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    divider_op_t          req_op;
    logic                 req_unsign;
    logic                 req_word;
    logic [WORD_BITS-1:0] req_a;
    logic [WORD_BITS-1:0] req_b;
    logic                 flush;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WORD_BITS-1:0] resp_data;
    logic                 busy;
    logic                 div_valid;
    divider_op_t          div_op;
    logic                 div_unsign;
    logic [WORD_BITS-1:0] div_a;
    logic [WORD_BITS-1:0] div_b;
    logic                 div_done;
    logic [WORD_BITS-1:0] div_c;

    modport slave (
        input  req_valid, req_op, req_unsign, req_word, req_a, req_b, flush,
               resp_ready, div_done, div_c,
        output req_ready, resp_valid, resp_data, busy,
               div_valid, div_op, div_unsign, div_a, div_b
    );

    modport master (
        output req_valid, req_op, req_unsign, req_word, req_a, req_b, flush,
               resp_ready, div_done, div_c,
        input  req_ready, resp_valid, resp_data, busy,
               div_valid, div_op, div_unsign, div_a, div_b
    );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - execute-stage sequencer for the shared iterative divider
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WORD_BITS = 64,
    parameter int HALF_BITS = 32
) (
    input logic       clk,
    input logic       resetn,
    div_ctrl_if.slave bus
);
    localparam int EXT_BITS = WORD_BITS - HALF_BITS;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP, DRAIN} state_t;

    state_t               state_q, state_d;
    divider_op_t          op_q;
    logic                 unsign_q, word_q, drain_q;
    logic [WORD_BITS-1:0] a_q, b_q, resp_q;
    logic [WORD_BITS-1:0] ext_a, ext_b, min_neg, fast_data, hit_data;
    logic                 accept, by_zero, overflow, hit;

    function automatic logic [WORD_BITS-1:0] extend(input logic [WORD_BITS-1:0] v,
                                                    input logic word, input logic unsign);
        if (!word) return v;
        if (unsign) return {{EXT_BITS{1'b0}}, v[HALF_BITS-1:0]};
        return {{EXT_BITS{v[HALF_BITS-1]}}, v[HALF_BITS-1:0]};
    endfunction

    function automatic logic [WORD_BITS-1:0] shape(input logic [WORD_BITS-1:0] v,
                                                   input logic word);
        return word ? {{EXT_BITS{v[HALF_BITS-1]}}, v[HALF_BITS-1:0]} : v;
    endfunction

    always_comb begin
        ext_a     = extend(bus.req_a, bus.req_word, bus.req_unsign);
        ext_b     = extend(bus.req_b, bus.req_word, bus.req_unsign);
        min_neg   = bus.req_word ? {{(EXT_BITS+1){1'b1}}, {(HALF_BITS-1){1'b0}}}
                                 : {1'b1, {(WORD_BITS-1){1'b0}}};
        by_zero   = (ext_b == '0);
        overflow  = !bus.req_unsign && (ext_b == '1) && (ext_a == min_neg);
        accept    = (state_q == IDLE) && bus.req_valid && !bus.flush;
        // Architectural results for the cases the divider never sees
        if (by_zero) fast_data = (bus.req_op == DIVOP) ? '1 : ext_a;
        else         fast_data = (bus.req_op == DIVOP) ? ext_a : '0;
        fast_data = shape(fast_data, bus.req_word);
    end

`ifdef DIV_RESULT_CACHE_EN
    logic                 c_valid, c_unsign, c_word, from_div_q;
    divider_op_t          c_op;
    logic [WORD_BITS-1:0] c_a, c_b, c_data;

    always_comb begin
        hit = c_valid && (c_op == bus.req_op) && (c_unsign == bus.req_unsign) &&
              (c_word == bus.req_word) && (c_a == ext_a) && (c_b == ext_b);
        hit_data = c_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            c_valid    <= 1'b0;
            c_op       <= DIVOP;
            c_unsign   <= 1'b0;
            c_word     <= 1'b0;
            c_a        <= '0;
            c_b        <= '0;
            c_data     <= '0;
            from_div_q <= 1'b0;
        end else begin
            if (accept) from_div_q <= 1'b0;
            else if (state_q == CAPT) from_div_q <= 1'b1;
            // Only a divider result the consumer actually took is remembered
            if (state_q == RESP && bus.resp_ready && !bus.flush && from_div_q) begin
                c_valid  <= 1'b1;
                c_op     <= op_q;
                c_unsign <= unsign_q;
                c_word   <= word_q;
                c_a      <= a_q;
                c_b      <= b_q;
                c_data   <= resp_q;
            end
        end
    end
`else
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = (by_zero || overflow || hit) ? RESP : ISSUE;
            ISSUE: state_d = bus.flush ? IDLE : WAIT;
            WAIT:  if (bus.flush) state_d = DRAIN;
                   else if (bus.div_done) state_d = CAPT;
            CAPT:  state_d = bus.flush ? IDLE : RESP;
            RESP:  if (bus.flush || bus.resp_ready) state_d = IDLE;
            DRAIN: if (drain_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            op_q     <= DIVOP;
            unsign_q <= 1'b0;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            resp_q   <= '0;
            drain_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= bus.req_op;
                unsign_q <= bus.req_unsign;
                word_q   <= bus.req_word;
                a_q      <= ext_a;
                b_q      <= ext_b;
                if (by_zero || overflow) resp_q <= fast_data;
                else if (hit)            resp_q <= hit_data;
            end
            if (state_q == CAPT && !bus.flush) resp_q <= shape(bus.div_c, word_q);
            // drain_q marks that div_done was seen; the following cycle retires the stale div_c
            if (state_q == WAIT && bus.flush) drain_q <= bus.div_done;
            else if (state_q == DRAIN)        drain_q <= !drain_q && bus.div_done;
            else                              drain_q <= 1'b0;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.div_valid  = (state_q == ISSUE) && !bus.flush;
    assign bus.div_op     = op_q;
    assign bus.div_unsign = unsign_q;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage sequencer for the shared 64-bit iterative divider.
- Accepts one DIV/REM request at a time from the execute pipe over a valid/ready handshake and applies RV64 W-suffix operand extension.
- Resolves divide-by-zero and signed overflow without engaging the divider; otherwise it issues, waits, captures and returns the result.
- Handles pipeline flush, including draining a divide that is already in flight.

Parameters:
WORD_BITS, 64, datapath width; W-ops operate on the low 32 bits.
HALF_BITS, 32, width of W-suffix operands.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_op  in  divider_op_t  DIVOP = quotient, REMOP = remainder
req_unsign  in  1  unsigned operation
req_word  in  1  W-suffix (32-bit) operation
req_a  in  WORD_BITS  dividend
req_b  in  WORD_BITS  divisor
flush  in  1  kill the current operation
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_data  out  WORD_BITS  result
busy  out  1  state != IDLE
div_valid  out  1  one-cycle start pulse to divider
div_op  out  divider_op_t  op to divider
div_unsign  out  1  signedness to divider
div_a, div_b  out  WORD_BITS  extended operands (registered)
div_done  in  1  divider finished or idle
div_c  in  WORD_BITS  divider result, valid the cycle after div_done rises

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low on resetn.
  - Reset state: IDLE.
  - Reset values: resp_valid=0, div_valid=0, busy=0, resp_data=0, operand registers 0, cache invalid.
  - Reset mid-operation abandons everything. The divider shares resetn, so it resets too.
- Operand extension at acceptance:
  - req_word=0: operands pass through unchanged.
  - req_word=1, unsigned: zero-extend bits [31:0].
  - req_word=1, signed: sign-extend bits [31:0].
  - Extended values are registered and driven as div_a/div_b.
- Result shaping:
  - req_word=1: resp_data = sign-extension of result bits [31:0].
  - Otherwise resp_data = the full result.
- States: IDLE, ISSUE, WAIT, CAPT, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && !flush: latch op, unsign, word and extended operands.
  - Divide-by-zero (extended b == 0): quotient = all ones, remainder = extended a. Go to RESP.
  - Signed overflow (!unsign, a = most negative value at the op width, b = -1): quotient = a, remainder = 0. Go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_valid=1 for exactly this cycle → WAIT.
  - div_done is ignored in ISSUE.
- WAIT: on div_done=1 → CAPT.
- CAPT: register the shaped div_c into resp_data → RESP.
- RESP:
  - resp_valid=1; resp_data stays stable until resp_ready.
  - resp_ready=1 → IDLE.
  - A new request is not accepted in the same cycle, so req_ready=0 in every state except IDLE.
- Flush handling (flush has priority over all other transitions):
  - ISSUE: div_valid suppressed, → IDLE.
  - WAIT: → DRAIN.
  - CAPT or RESP: → IDLE, result discarded, resp_valid drops next cycle.
- DRAIN:
  - Waits for div_done=1, then one further cycle so div_c is consumed and discarded, then → IDLE.
  - req_ready=0 throughout.
  - flush in DRAIN has no further effect.
- Latency from acceptance edge to resp_valid:
  - Fast path: 1 cycle.
  - Normal path: D+3 cycles, where D = cycles from div_valid to div_done.
- Throughput: one operation in flight; back-to-back requests incur one IDLE cycle between them.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Defined:
  - After each completed, unflushed normal-path result, store {op, unsign, word, extended a, extended b, resp_data} and mark the entry valid.
  - A request matching all stored fields in IDLE → RESP the next cycle with the stored data; the divider is not started.
  - The cache is invalidated by reset only. Flushed or drained operations never update it.
- Not defined: every non-fast-path request uses the divider; no cache storage is synthesized.

Test Plan:
- Signed DIV a=-7, b=2 → div_valid pulses once, resp_data=-3 (0xFFFF_FFFF_FFFF_FFFD) after D+3 cycles. REMOP with the same operands → -1.
- DIVOP a=5, b=0 → resp_valid 1 cycle after acceptance with 0xFFFF_FFFF_FFFF_FFFF, div_valid never asserted. REMOP with the same operands → 5.
- Signed W DIV a=0x0000_0000_8000_0000, b=0xFFFF_FFFF → fast path, resp_data=0xFFFF_FFFF_8000_0000. Unsigned W REM a=0x1_0000_0007, b=3 → 1.
- Flush asserted 10 cycles into WAIT → DRAIN, resp_valid never asserted, req_ready stays 0 until div_done + 1 cycle. A following request a=100, b=7 (DIVOP) → 14.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_data stable, req_ready=0. Release → IDLE next cycle.
- With DIV_RESULT_CACHE_EN: repeat an identical request a=1000, b=9 (DIVOP) → second response 111 arrives 1 cycle after acceptance, no div_valid. Without the macro: full D+3 latency.
